// File: rtl/stereo_stream_source_if.sv
// Valid/ready pixel-pair handshake between an upstream stereo source and
// the stream transmitter.
interface stereo_stream_source_if;
  logic       src_valid;
  logic [7:0] src_left;
  logic [7:0] src_right;
  logic       src_ready;

  modport master (output src_valid, output src_left, output src_right, input src_ready);
  modport slave  (input src_valid, input src_left, input src_right, output src_ready);
endinterface

// File: rtl/stereo_stream_source.sv
// Stereo video transmitter: raster timing generator that pulls left/right
// pixel pairs from a valid/ready source and emits registered de/sync/pixels.
module stereo_stream_source #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter int ROW_WIDTH = 10,
  parameter int COL_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  stereo_stream_source_if.slave  src,
  output logic                   de_o,
  output logic                   h_sync_o,
  output logic                   v_sync_o,
  output logic [7:0]             pixel_left_o,
  output logic [7:0]             pixel_right_o,
  output logic [ROW_WIDTH-1:0]   row_o,
  output logic [COL_WIDTH-1:0]   col_o,
  output logic                   frame_start_o,
  output logic                   underflow_o
);

  localparam logic [COL_WIDTH-1:0] H_LAST   = COL_WIDTH'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [ROW_WIDTH-1:0] V_LAST   = ROW_WIDTH'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COL_WIDTH-1:0] H_ACT    = COL_WIDTH'(H_ACTIVE);
  localparam logic [COL_WIDTH-1:0] HS_BEGIN = COL_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [COL_WIDTH-1:0] HS_END   = COL_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [ROW_WIDTH-1:0] V_ACT    = ROW_WIDTH'(V_ACTIVE);
  localparam logic [ROW_WIDTH-1:0] VS_BEGIN = ROW_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [ROW_WIDTH-1:0] VS_END   = ROW_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [COL_WIDTH-1:0]   h_cnt_q, h_cnt_d;
  logic [ROW_WIDTH-1:0]   v_cnt_q, v_cnt_d;
  logic                   active_s, hs_s, vs_s;

  logic                   de_q, hs_q, vs_q, fs_q, uf_q;
  logic [7:0]             pl_q, pr_q;
  logic [ROW_WIDTH-1:0]   row_q;
  logic [COL_WIDTH-1:0]   col_q;

  always_comb begin
    state_d  = state_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    active_s = 1'b0;
    hs_s     = 1'b0;
    vs_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (en_i) state_d = S_RUN;
        else      state_d = S_IDLE;
      end
      S_RUN: begin
        active_s = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_s     = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
        vs_s     = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          // en is only honoured at the frame boundary so frames are never truncated
          if (v_cnt_q == V_LAST) begin
            v_cnt_d = '0;
            if (en_i) state_d = S_RUN;
            else      state_d = S_IDLE;
          end else begin
            v_cnt_d = v_cnt_q + ROW_WIDTH'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + COL_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        h_cnt_d = '0;
        v_cnt_d = '0;
      end
    endcase
  end

  assign src.src_ready = active_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Timing never stalls: a missing pair yields zero pixels and a sticky underflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q  <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      fs_q  <= 1'b0;
      uf_q  <= 1'b0;
      pl_q  <= 8'd0;
      pr_q  <= 8'd0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      de_q  <= active_s;
      hs_q  <= hs_s;
      vs_q  <= vs_s;
      fs_q  <= active_s && (h_cnt_q == '0) && (v_cnt_q == '0);
      uf_q  <= uf_q | (active_s & ~src.src_valid);
      pl_q  <= (active_s && src.src_valid) ? src.src_left  : 8'd0;
      pr_q  <= (active_s && src.src_valid) ? src.src_right : 8'd0;
      row_q <= (state_q == S_RUN) ? v_cnt_q : '0;
      col_q <= (state_q == S_RUN) ? h_cnt_q : '0;
    end
  end

  assign de_o          = de_q;
  assign h_sync_o      = hs_q;
  assign v_sync_o      = vs_q;
  assign frame_start_o = fs_q;
  assign underflow_o   = uf_q;
  assign pixel_left_o  = pl_q;
  assign pixel_right_o = pr_q;
  assign row_o         = row_q;
  assign col_o         = col_q;

endmodule

// File: tb/tb_stereo_stream_source.sv
// Directed bench for stereo_stream_source on an 8x5 raster (4x2 active).
module tb_stereo_stream_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        de, hs, vs, fs, uf;
  logic [7:0]  pl, pr;
  logic [9:0]  row;
  logic [10:0] col;

  stereo_stream_source_if src_if ();

  stereo_stream_source #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .ROW_WIDTH(10), .COL_WIDTH(11)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en), .src(src_if),
    .de_o(de), .h_sync_o(hs), .v_sync_o(vs),
    .pixel_left_o(pl), .pixel_right_o(pr),
    .row_o(row), .col_o(col),
    .frame_start_o(fs), .underflow_o(uf)
  );

  always #5 clk = ~clk;

  typedef struct { bit act; bit hs; } hvec_t;
  typedef struct { bit act; bit vs; } vvec_t;
  hvec_t col_tbl[8];
  vvec_t line_tbl[5];

  int total = 0;
  int bad = 0;
  int n = 0;
  int rdy_cnt;
  bit exp_uf = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Drive one counter-state cycle k of a frame, then check the registered outputs for it
  task automatic one_cycle(input int k, input bit valid);
    int r, c;
    bit act;
    int el, er;
    r = k / 8;
    c = k % 8;
    act = line_tbl[r].act && col_tbl[c].act;
    src_if.src_valid = valid;
    src_if.src_left  = 8'(n);
    src_if.src_right = 8'(n + 100);
    chk("src_ready", int'(src_if.src_ready), int'(act));
    if (src_if.src_ready) rdy_cnt++;
    @(posedge clk);
    if (act && valid) begin
      el = n % 256;
      er = (n + 100) % 256;
      n++;
    end else begin
      el = 0;
      er = 0;
    end
    if (act && !valid) exp_uf = 1'b1;
    #1;
    chk("de", int'(de), int'(act));
    chk("h_sync", int'(hs), int'(col_tbl[c].hs));
    chk("v_sync", int'(vs), int'(line_tbl[r].vs));
    chk("row", int'(row), r);
    chk("col", int'(col), c);
    chk("frame_start", int'(fs), int'(k == 0));
    chk("pixel_left", int'(pl), el);
    chk("pixel_right", int'(pr), er);
    chk("underflow", int'(uf), int'(exp_uf));
  endtask

  task automatic run_frame(input int drop_k, input int en_off_k);
    rdy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == en_off_k) en = 1'b0;
      one_cycle(k, k != drop_k);
    end
    chk("ready_per_frame", rdy_cnt, 8);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_de"}, int'(de), 0);
    chk({nm, "_hs"}, int'(hs), 0);
    chk({nm, "_vs"}, int'(vs), 0);
    chk({nm, "_fs"}, int'(fs), 0);
    chk({nm, "_pix"}, int'(pl) + int'(pr), 0);
    chk({nm, "_rowcol"}, int'(row) + int'(col), 0);
    chk({nm, "_ready"}, int'(src_if.src_ready), 0);
  endtask

  initial begin
    col_tbl[0] = '{act: 1'b1, hs: 1'b0};
    col_tbl[1] = '{act: 1'b1, hs: 1'b0};
    col_tbl[2] = '{act: 1'b1, hs: 1'b0};
    col_tbl[3] = '{act: 1'b1, hs: 1'b0};
    col_tbl[4] = '{act: 1'b0, hs: 1'b0};
    col_tbl[5] = '{act: 1'b0, hs: 1'b1};
    col_tbl[6] = '{act: 1'b0, hs: 1'b1};
    col_tbl[7] = '{act: 1'b0, hs: 1'b0};
    line_tbl[0] = '{act: 1'b1, vs: 1'b0};
    line_tbl[1] = '{act: 1'b1, vs: 1'b0};
    line_tbl[2] = '{act: 1'b0, vs: 1'b0};
    line_tbl[3] = '{act: 1'b0, vs: 1'b1};
    line_tbl[4] = '{act: 1'b0, vs: 1'b0};

    src_if.src_valid = 1'b1;
    src_if.src_left  = 8'd0;
    src_if.src_right = 8'd0;

    // Reset state, then en held low for 100 clocks
    #12;
    check_all_zero("reset");
    chk("reset_underflow", int'(uf), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk("idle_ready", int'(src_if.src_ready), 0);
      @(posedge clk); #1;
      chk("idle_de", int'(de), 0);
      chk("idle_uf", int'(uf), 0);
    end
    check_all_zero("idle_end");

    // Two back-to-back frames with incrementing source data
    en = 1'b1;
    @(posedge clk); #1;
    run_frame(-1, -1);
    chk("pairs_after_frame1", n, 8);
    run_frame(-1, -1);

    // Underflow at the third active pixel, sticky through the next frame
    run_frame(2, -1);
    run_frame(-1, -1);

    // en dropped at clock 10 still completes the frame
    run_frame(-1, 10);
    for (int i = 0; i < 20; i++) begin
      chk("off_ready", int'(src_if.src_ready), 0);
      @(posedge clk); #1;
      check_all_zero("off");
      chk("off_uf", int'(uf), 1);
    end
    en = 1'b1;
    @(posedge clk); #1;
    run_frame(-1, -1);

    // Asynchronous reset during an active pixel
    rdy_cnt = 0;
    for (int k = 0; k < 3; k++) one_cycle(k, 1'b1);
    chk("pre_reset_de", int'(de), 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    chk("async_rst_uf", int'(uf), 0);
    exp_uf = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(-1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
